// File: rtl/gomoku_board_ctrl_if.sv
// Button, read-port and status bundle between gomoku_board_ctrl and its host/renderer.
// No handshake: buttons are single-cycle pulses, status lines are level outputs.
interface gomoku_board_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_place;
  logic       restart;
  logic [4:0] rd_row;
  logic [4:0] rd_col;
  logic [1:0] rd_cell;
  logic [4:0] cur_row;
  logic [4:0] cur_col;
  logic       turn;
  logic       busy;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_place, restart, rd_row, rd_col,
    input  rd_cell, cur_row, cur_col, turn, busy, game_over, winner
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_place, restart, rd_row, rd_col,
    output rd_cell, cur_row, cur_col, turn, busy, game_over, winner
  );
endinterface

// File: rtl/gomoku_board_ctrl.sv
// Gomoku board state, cursor and side-to-move with a sequential five-in-a-row check after each stone.
// Read port has 1-cycle latency; buttons other than restart are dropped while busy (no queuing).
module gomoku_board_ctrl #(
  parameter int GRID    = 19,
  parameter int WIN_LEN = 5
) (
  input  logic                clk,
  input  logic                rst,
  gomoku_board_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, PLACE, SCAN_POS, SCAN_NEG, NEXT_DIR, DONE} state_t;

  localparam int                KW     = $clog2(WIN_LEN);
  localparam int                RW     = $clog2(2 * WIN_LEN);
  localparam logic [4:0]        CENTER = 5'(GRID / 2);
  localparam logic [4:0]        LAST   = 5'(GRID - 1);
  localparam logic [8:0]        CELLS  = 9'(GRID * GRID);
  localparam logic [KW-1:0]     K_LAST = KW'(WIN_LEN - 1);
  localparam logic signed [5:0] GRID_S = 6'(GRID);

  logic [1:0]    board_q [GRID][GRID];
  logic [1:0]    board_d [GRID][GRID];
  state_t        state_q, state_d;
  logic [4:0]    cur_row_q, cur_row_d, cur_col_q, cur_col_d;
  logic [4:0]    pr_q, pr_d, pc_q, pc_d;
  logic [1:0]    colour_q, colour_d;
  logic [1:0]    dir_q, dir_d;
  logic [KW-1:0] k_q, k_d;
  logic [RW-1:0] run_q, run_d;
  logic [8:0]    count_q, count_d;
  logic          turn_q, turn_d, game_over_q, game_over_d;
  logic [1:0]    winner_q, winner_d, rd_cell_q, rd_cell_d;

  logic signed [5:0] k_s, r_step, c_step, probe_r, probe_c;
  logic              probe_in, probe_hit;

  // Probe (pr,pc) +/- k*dir; the sign flips for the negative half-scan.
  always_comb begin
    k_s    = 6'(k_q);
    r_step = (dir_q == 2'd0) ? 6'sd0 : k_s;
    case (dir_q)
      2'd0, 2'd2: c_step = k_s;
      2'd1:       c_step = 6'sd0;
      default:    c_step = -k_s;
    endcase
    if (state_q == SCAN_NEG) begin
      r_step = -r_step;
      c_step = -c_step;
    end
    probe_r   = $signed({1'b0, pr_q}) + r_step;
    probe_c   = $signed({1'b0, pc_q}) + c_step;
    probe_in  = (probe_r >= 6'sd0) && (probe_r < GRID_S) &&
                (probe_c >= 6'sd0) && (probe_c < GRID_S);
    probe_hit = 1'b0;
    if (probe_in) begin
      probe_hit = (board_q[probe_r[4:0]][probe_c[4:0]] == colour_q);
    end
  end

  always_comb begin
    rd_cell_d = 2'b00;
    if ((bus.rd_row < 5'(GRID)) && (bus.rd_col < 5'(GRID))) begin
      rd_cell_d = board_q[bus.rd_row][bus.rd_col];
    end
  end

  always_comb begin
    board_d     = board_q;
    state_d     = state_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    pr_d        = pr_q;
    pc_d        = pc_q;
    colour_d    = colour_q;
    dir_d       = dir_q;
    k_d         = k_q;
    run_d       = run_q;
    count_d     = count_q;
    turn_d      = turn_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;

    if (bus.restart) begin
      for (int r = 0; r < GRID; r++) begin
        for (int c = 0; c < GRID; c++) begin
          board_d[r][c] = 2'b00;
        end
      end
      state_d     = IDLE;
      cur_row_d   = CENTER;
      cur_col_d   = CENTER;
      dir_d       = 2'd0;
      k_d         = KW'(1);
      run_d       = RW'(1);
      count_d     = 9'd0;
      turn_d      = 1'b0;
      game_over_d = 1'b0;
      winner_d    = 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (!game_over_q) begin
            if (bus.btn_up) begin
              cur_row_d = (cur_row_q == 5'd0) ? LAST : cur_row_q - 5'd1;
            end else if (bus.btn_down) begin
              cur_row_d = (cur_row_q == LAST) ? 5'd0 : cur_row_q + 5'd1;
            end else if (bus.btn_left) begin
              cur_col_d = (cur_col_q == 5'd0) ? LAST : cur_col_q - 5'd1;
            end else if (bus.btn_right) begin
              cur_col_d = (cur_col_q == LAST) ? 5'd0 : cur_col_q + 5'd1;
            end else if (bus.btn_place && (board_q[cur_row_q][cur_col_q] == 2'b00)) begin
              pr_d     = cur_row_q;
              pc_d     = cur_col_q;
              colour_d = turn_q ? 2'b10 : 2'b01;
              state_d  = PLACE;
            end
          end
        end
        PLACE: begin
          board_d[pr_q][pc_q] = colour_q;
          count_d = count_q + 9'd1;
          dir_d   = 2'd0;
          k_d     = KW'(1);
          run_d   = RW'(1);
          state_d = SCAN_POS;
        end
        SCAN_POS, SCAN_NEG: begin
          if (probe_hit) begin
            run_d = run_q + RW'(1);
          end
          // A miss or the last step both end this half-scan after using the cycle.
          if (!probe_hit || (k_q == K_LAST)) begin
            k_d     = KW'(1);
            state_d = (state_q == SCAN_POS) ? SCAN_NEG : NEXT_DIR;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        NEXT_DIR: begin
          if (run_q >= RW'(WIN_LEN)) begin
            winner_d    = colour_q;
            game_over_d = 1'b1;
            state_d     = DONE;
          end else if (dir_q != 2'd3) begin
            dir_d   = dir_q + 2'd1;
            k_d     = KW'(1);
            run_d   = RW'(1);
            state_d = SCAN_POS;
          end else if (count_q == CELLS) begin
            winner_d    = 2'b11;
            game_over_d = 1'b1;
            state_d     = DONE;
          end else begin
            turn_d  = ~turn_q;
            state_d = IDLE;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < GRID; r++) begin
        for (int c = 0; c < GRID; c++) begin
          board_q[r][c] <= 2'b00;
        end
      end
      state_q     <= IDLE;
      cur_row_q   <= CENTER;
      cur_col_q   <= CENTER;
      pr_q        <= 5'd0;
      pc_q        <= 5'd0;
      colour_q    <= 2'b00;
      dir_q       <= 2'd0;
      k_q         <= KW'(1);
      run_q       <= RW'(1);
      count_q     <= 9'd0;
      turn_q      <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 2'b00;
      rd_cell_q   <= 2'b00;
    end else begin
      board_q     <= board_d;
      state_q     <= state_d;
      cur_row_q   <= cur_row_d;
      cur_col_q   <= cur_col_d;
      pr_q        <= pr_d;
      pc_q        <= pc_d;
      colour_q    <= colour_d;
      dir_q       <= dir_d;
      k_q         <= k_d;
      run_q       <= run_d;
      count_q     <= count_d;
      turn_q      <= turn_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      rd_cell_q   <= rd_cell_d;
    end
  end

  assign bus.rd_cell   = rd_cell_q;
  assign bus.cur_row   = cur_row_q;
  assign bus.cur_col   = cur_col_q;
  assign bus.turn      = turn_q;
  assign bus.game_over = game_over_q;
  assign bus.winner    = winner_q;
  assign bus.busy      = (state_q == PLACE) || (state_q == SCAN_POS) ||
                         (state_q == SCAN_NEG) || (state_q == NEXT_DIR);

endmodule
